// File: rtl/write_buffer_pool.sv
// Pooled write buffer: free-id allocator, byte-enable merge, 1-cycle read, release, error pulse.
// Optional MPC_WBUF_BYPASS_EN: a read colliding with a same-cycle write returns the merged data.
module write_buffer_pool #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8,
  parameter int ID_W   = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  output logic [ID_W-1:0]   alloc_id_o,
  input  logic              wr_valid_i,
  input  logic [ID_W-1:0]   wr_id_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [BE_W-1:0]   wr_be_i,
  input  logic              rd_valid_i,
  input  logic [ID_W-1:0]   rd_id_i,
  input  logic              rd_release_i,
  output logic              rd_rsp_valid_o,
  output logic [ID_W-1:0]   rd_rsp_id_o,
  output logic [DATA_W-1:0] rd_rsp_data_o,
  output logic              free_valid_o,
  output logic [ID_W-1:0]   free_id_o,
  output logic [ID_W:0]     occupancy_o,
  output logic              err_o
);

  logic [DEPTH-1:0]  used_q, used_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ID_W:0]     occ_q, occ_d;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              free_valid_q;
  logic [ID_W-1:0]   free_id_q;
  logic              err_q, err_d;

  logic              alloc_fire, wr_ok, rd_hit, rel_fire;
  logic [DATA_W-1:0] merged;

  // Lowest-index free entry; a same-cycle release is still marked used here.
  always_comb begin
    alloc_ready_o = ~&used_q;
    alloc_id_o    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!used_q[i]) alloc_id_o = ID_W'(i);
    end
  end

  assign alloc_fire = alloc_valid_i && alloc_ready_o;
  assign wr_ok      = wr_valid_i && used_q[wr_id_i];
  assign rd_hit     = used_q[rd_id_i];
  assign rel_fire   = rd_valid_i && rd_release_i && rd_hit;

  always_comb begin
    merged = data_q[wr_id_i];
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be_i[b]) merged[b*8 +: 8] = wr_data_i[b*8 +: 8];
    end
  end

  always_comb begin
    rsp_data_d = '0;
    if (rd_hit) begin
`ifdef MPC_WBUF_BYPASS_EN
      rsp_data_d = (wr_ok && (wr_id_i == rd_id_i)) ? merged : data_q[rd_id_i];
`else
      rsp_data_d = data_q[rd_id_i];
`endif
    end
  end

  always_comb begin
    used_d = used_q;
    if (rel_fire)   used_d[rd_id_i]    = 1'b0;
    if (alloc_fire) used_d[alloc_id_o] = 1'b1;
    occ_d = occ_q + (ID_W+1)'(alloc_fire) - (ID_W+1)'(rel_fire);
    err_d = (wr_valid_i && !used_q[wr_id_i]) ||
            (rd_valid_i && !rd_hit) ||
            (alloc_valid_i && !alloc_ready_o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_q       <= '0;
      occ_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      free_valid_q <= 1'b0;
      free_id_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      used_q       <= used_d;
      occ_q        <= occ_d;
      rsp_valid_q  <= rd_valid_i;
      rsp_id_q     <= rd_valid_i ? rd_id_i : '0;
      rsp_data_q   <= rd_valid_i ? rsp_data_d : '0;
      free_valid_q <= rel_fire;
      free_id_q    <= rel_fire ? rd_id_i : '0;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (wr_ok) begin
      data_q[wr_id_i] <= merged;
    end
  end

  assign rd_rsp_valid_o = rsp_valid_q;
  assign rd_rsp_id_o    = rsp_id_q;
  assign rd_rsp_data_o  = rsp_data_q;
  assign free_valid_o   = free_valid_q;
  assign free_id_o      = free_id_q;
  assign occupancy_o    = occ_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_write_buffer_pool.sv
// Directed bench for write_buffer_pool with a reference model and a response scoreboard queue.
module tb_write_buffer_pool;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 8;
  localparam int ID_W   = 3;
  localparam int BE_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic              alloc_valid = 1'b0;
  logic              alloc_ready;
  logic [ID_W-1:0]   alloc_id;
  logic              wr_valid = 1'b0;
  logic [ID_W-1:0]   wr_id = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [BE_W-1:0]   wr_be = '0;
  logic              rd_valid = 1'b0;
  logic [ID_W-1:0]   rd_id = '0;
  logic              rd_release = 1'b0;
  logic              rd_rsp_valid;
  logic [ID_W-1:0]   rd_rsp_id;
  logic [DATA_W-1:0] rd_rsp_data;
  logic              free_valid;
  logic [ID_W-1:0]   free_id;
  logic [ID_W:0]     occupancy;
  logic              err;

  write_buffer_pool #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
    .wr_valid_i(wr_valid), .wr_id_i(wr_id), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_valid_i(rd_valid), .rd_id_i(rd_id), .rd_release_i(rd_release),
    .rd_rsp_valid_o(rd_rsp_valid), .rd_rsp_id_o(rd_rsp_id), .rd_rsp_data_o(rd_rsp_data),
    .free_valid_o(free_valid), .free_id_o(free_id), .occupancy_o(occupancy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t            rsp_q[$];
  logic [ID_W-1:0] free_q[$];
  logic            exp_err;
  logic            m_used [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  int              m_occ;
  int              tests = 0;
  int              fails = 0;
  bit              bypass;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_used[i] = 1'b0;
      m_data[i] = '0;
    end
    m_occ = 0;
    exp_err = 1'b0;
    rsp_q.delete();
    free_q.delete();
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; wr_valid = 1'b0; wr_be = '0; wr_data = '0;
    rd_valid = 1'b0; rd_release = 1'b0; wr_id = '0; rd_id = '0;
  endtask

  // One clock: predict from the model, push expectations, advance, then compare.
  task automatic cycle(input string tag);
    logic              rdy, a_fire, w_ok, r_ok, rel;
    logic [ID_W-1:0]   aid;
    logic [DATA_W-1:0] mrg, rdat;
    rsp_t              r;
    rdy = 1'b0; aid = '0;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_used[i]) begin rdy = 1'b1; aid = ID_W'(i); end
    chk({tag, ".alloc_ready"}, DATA_W'(alloc_ready), DATA_W'(rdy));
    if (rdy) chk({tag, ".alloc_id"}, DATA_W'(alloc_id), DATA_W'(aid));
    a_fire = alloc_valid && rdy;
    w_ok = wr_valid && m_used[wr_id];
    r_ok = rd_valid && m_used[rd_id];
    exp_err = (wr_valid && !m_used[wr_id]) || (rd_valid && !m_used[rd_id]) || (alloc_valid && !rdy);
    mrg = m_data[wr_id];
    for (int b = 0; b < BE_W; b++) if (wr_be[b]) mrg[b*8 +: 8] = wr_data[b*8 +: 8];
    if (rd_valid) begin
      rdat = '0;
      if (r_ok) rdat = (bypass && w_ok && wr_id == rd_id) ? mrg : m_data[rd_id];
      rsp_q.push_back('{id: rd_id, data: rdat});
    end
    rel = rd_valid && rd_release && r_ok;
    if (rel) free_q.push_back(rd_id);
    if (w_ok) m_data[wr_id] = mrg;
    if (rel) m_used[rd_id] = 1'b0;
    if (a_fire) m_used[aid] = 1'b1;
    m_occ = m_occ + int'(a_fire) - int'(rel);
    @(posedge clk); #1;
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      chk({tag, ".rsp_valid"}, DATA_W'(rd_rsp_valid), DATA_W'(1));
      chk({tag, ".rsp_id"}, DATA_W'(rd_rsp_id), DATA_W'(r.id));
      chk({tag, ".rsp_data"}, rd_rsp_data, r.data);
    end else begin
      chk({tag, ".rsp_valid"}, DATA_W'(rd_rsp_valid), DATA_W'(0));
    end
    if (free_q.size() > 0) begin
      chk({tag, ".free_valid"}, DATA_W'(free_valid), DATA_W'(1));
      chk({tag, ".free_id"}, DATA_W'(free_id), DATA_W'(free_q.pop_front()));
    end else begin
      chk({tag, ".free_valid"}, DATA_W'(free_valid), DATA_W'(0));
    end
    chk({tag, ".err"}, DATA_W'(err), DATA_W'(exp_err));
    chk({tag, ".occupancy"}, DATA_W'(occupancy), DATA_W'(m_occ));
    idle_inputs();
  endtask

  initial begin
`ifdef MPC_WBUF_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    model_reset();
    idle_inputs();
    #12 rst_n = 1'b1;
    @(negedge clk);

    // T1 reset state
    chk("t1.occupancy", DATA_W'(occupancy), '0);
    chk("t1.alloc_ready", DATA_W'(alloc_ready), DATA_W'(1));
    chk("t1.alloc_id", DATA_W'(alloc_id), '0);
    chk("t1.outs", DATA_W'({rd_rsp_valid, free_valid, err}), '0);

    // T2 fill all entries, then one alloc too many
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2.order", DATA_W'(alloc_id), DATA_W'(i));
      alloc_valid = 1'b1;
      cycle("t2.alloc");
    end
    chk("t2.full_occ", DATA_W'(occupancy), DATA_W'(8));
    chk("t2.full_ready", DATA_W'(alloc_ready), DATA_W'(0));
    alloc_valid = 1'b1;
    cycle("t2.over");
    chk("t2.over_err", DATA_W'(err), DATA_W'(1));

    // T4 release id3 with a same-cycle alloc attempt while full
    rd_valid = 1'b1; rd_id = 3'd3; rd_release = 1'b1; alloc_valid = 1'b1;
    cycle("t4.rel");
    chk("t4.err", DATA_W'(err), DATA_W'(1));
    chk("t4.occ", DATA_W'(occupancy), DATA_W'(7));
    chk("t4.free_id", DATA_W'(free_id), DATA_W'(3));
    chk("t4.alloc_id", DATA_W'(alloc_id), DATA_W'(3));
    alloc_valid = 1'b1;
    cycle("t4.realloc");

    // T3 full write then single-byte merge
    wr_valid = 1'b1; wr_id = 3'd0; wr_data = '1; wr_be = '1;
    cycle("t3.wr_all");
    wr_valid = 1'b1; wr_id = 3'd0; wr_data = DATA_W'(8'hAB); wr_be = BE_W'(1);
    cycle("t3.wr_byte");
    wr_valid = 1'b1; wr_id = 3'd0; wr_data = '0; wr_be = '0;
    cycle("t3.wr_noop");
    rd_valid = 1'b1; rd_id = 3'd0;
    cycle("t3.rd");
    chk("t3.data", rd_rsp_data, {{(DATA_W-8){1'b1}}, 8'hAB});

    // T5 write and read of the same entry in one cycle
    wr_valid = 1'b1; wr_id = 3'd2; wr_data = DATA_W'(16'h1234); wr_be = '1;
    rd_valid = 1'b1; rd_id = 3'd2;
    cycle("t5.collide");
    chk("t5.collide_data", rd_rsp_data, bypass ? DATA_W'(16'h1234) : '0);
    rd_valid = 1'b1; rd_id = 3'd2;
    cycle("t5.follow");
    chk("t5.follow_data", rd_rsp_data, DATA_W'(16'h1234));

    // Partial merge on a different entry with a scattered byte mask
    wr_valid = 1'b1; wr_id = 3'd4; wr_data = {DATA_W/32{32'hC0DE_F00D}}; wr_be = 16'hA5A5;
    cycle("x.wr_mask");
    rd_valid = 1'b1; rd_id = 3'd4;
    cycle("x.rd_mask");

    // Write + release on the same id: data kept, entry freed
    wr_valid = 1'b1; wr_id = 3'd5; wr_data = DATA_W'(32'h5555_AAAA); wr_be = '1;
    rd_valid = 1'b1; rd_id = 3'd5; rd_release = 1'b1;
    cycle("x.wr_rel");

    // T6 write and read to the free entry 5
    wr_valid = 1'b1; wr_id = 3'd5; wr_data = '1; wr_be = '1;
    cycle("t6.wr_free");
    chk("t6.err", DATA_W'(err), DATA_W'(1));
    rd_valid = 1'b1; rd_id = 3'd5;
    cycle("t6.rd_free");
    chk("t6.rd_free_data", rd_rsp_data, '0);

    // Alloc + write to the id being allocated is an error
    alloc_valid = 1'b1; wr_valid = 1'b1; wr_id = 3'd5; wr_data = '0; wr_be = '1;
    cycle("x.alloc_wr");
    rd_valid = 1'b1; rd_id = 3'd5;
    cycle("t6.rd_realloc");
    chk("t6.kept", rd_rsp_data, DATA_W'(32'h5555_AAAA));

    // Reset with a response in flight
    rd_valid = 1'b1; rd_id = 3'd2; rd_release = 1'b1;
    cycle("t6.pre_rst");
    #1 rst_n = 1'b0;
    #1;
    chk("rst.rsp_valid", DATA_W'(rd_rsp_valid), '0);
    chk("rst.rsp_data", rd_rsp_data, '0);
    chk("rst.free_valid", DATA_W'(free_valid), '0);
    chk("rst.occupancy", DATA_W'(occupancy), '0);
    chk("rst.alloc_id", DATA_W'(alloc_id), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    alloc_valid = 1'b1;
    cycle("post_rst.alloc");
    rd_valid = 1'b1; rd_id = 3'd0;
    cycle("post_rst.rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
